// File: rtl/pixel_write_sink_pkg.sv
// Shared screen geometry, pixel word layout and controller state encoding
// for the pixel write sink and its FIFO.
package pixel_write_sink_pkg;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;
  localparam int unsigned COLOUR_W = 3;
  localparam int unsigned ADDR_W   = 15;
  localparam int unsigned X_W      = 8;
  localparam int unsigned Y_W      = 7;
  localparam int unsigned PIXEL_W  = X_W + Y_W + COLOUR_W;

  typedef struct packed {
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
  } pixel_t;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDrain = 2'd1,
    StClear = 2'd2
  } state_e;

  // Row-major framebuffer address; a constant width folds to shift-and-add.
  function automatic logic [ADDR_W-1:0] pixel_addr(input pixel_t p, input int unsigned width);
    return ADDR_W'(p.y) * ADDR_W'(width) + ADDR_W'(p.x);
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO of pending pixel writes; first-word fall-through read port.
module pixel_fifo #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 18
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [PtrW:0]    wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]    rd_ptr_q, rd_ptr_d;
  logic [Width-1:0] mem_q [Depth];
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                   (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign rdata_o = mem_q[rd_ptr_q[PtrW-1:0]];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (PtrW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (PtrW+1)'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[PtrW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/pixel_write_sink.sv
// Accepts pixel-plot requests, queues them, and streams framebuffer writes;
// a clear request drains the queue and then fills the whole screen.
module pixel_write_sink #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned SCREEN_W   = pixel_write_sink_pkg::SCREEN_W,
  parameter int unsigned SCREEN_H   = pixel_write_sink_pkg::SCREEN_H
) (
  input  logic                                      clock,
  input  logic                                      resetn,
  input  logic                                      plot,
  input  logic [7:0]                                x,
  input  logic [6:0]                                y,
  input  logic [pixel_write_sink_pkg::COLOUR_W-1:0] colour,
  output logic                                      ready,
  input  logic                                      clear_req,
  input  logic [pixel_write_sink_pkg::COLOUR_W-1:0] clear_colour,
  output logic                                      busy,
  output logic [pixel_write_sink_pkg::ADDR_W-1:0]   mem_addr,
  output logic [pixel_write_sink_pkg::COLOUR_W-1:0] mem_data,
  output logic                                      mem_we,
  output logic [7:0]                                dropped_count
);

  import pixel_write_sink_pkg::*;

  localparam logic [ADDR_W-1:0] ClearEnd = ADDR_W'(SCREEN_W * SCREEN_H);

  state_e              state_q, state_d;
  logic [COLOUR_W-1:0] clr_colour_q, clr_colour_d;
  logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [COLOUR_W-1:0] mem_data_q, mem_data_d;
  logic [7:0]          dropped_q, dropped_d;

  logic                in_range, accept, push, pop;
  logic                fifo_full, fifo_empty;
  pixel_t              wr_pixel, rd_pixel;
  logic [PIXEL_W-1:0]  rd_word;

  assign wr_pixel = '{x: x, y: y, colour: colour};
  assign rd_pixel = pixel_t'(rd_word);

  // resetn gates ready so the handshake is closed while reset is held.
  assign ready    = resetn && (state_q == StIdle) && !fifo_full;
  assign in_range = (32'(x) < SCREEN_W) && (32'(y) < SCREEN_H);
  assign accept   = plot && ready;
  assign push     = accept && in_range;
  assign pop      = (state_q != StClear) && !fifo_empty;

  assign busy          = (state_q != StIdle);
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_data      = mem_data_q;
  assign dropped_count = dropped_q;

  pixel_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (PIXEL_W)
  ) u_fifo (
    .clk_i   (clock),
    .rst_ni  (resetn),
    .push_i  (push),
    .wdata_i (wr_pixel),
    .pop_i   (pop),
    .rdata_o (rd_word),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d      = state_q;
    clr_colour_d = clr_colour_q;
    clr_addr_d   = clr_addr_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    dropped_d    = dropped_q;

    if (accept && !in_range && (dropped_q != 8'hFF)) dropped_d = dropped_q + 8'd1;

    if (pop) begin
      mem_we_d   = 1'b1;
      mem_addr_d = pixel_addr(rd_pixel, SCREEN_W);
      mem_data_d = rd_pixel.colour;
    end

    unique case (state_q)
      StIdle: begin
        if (clear_req) begin
          state_d      = StDrain;
          clr_colour_d = clear_colour;
          clr_addr_d   = '0;
        end
      end
      StDrain: begin
        if (fifo_empty) state_d = StClear;
      end
      StClear: begin
        // Stay one extra cycle so busy drops only after the last write is visible.
        if (clr_addr_q == ClearEnd) begin
          state_d = StIdle;
        end else begin
          mem_we_d   = 1'b1;
          mem_addr_d = clr_addr_q;
          mem_data_d = clr_colour_q;
          clr_addr_d = clr_addr_q + ADDR_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      clr_colour_q <= '0;
      clr_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      dropped_q    <= '0;
    end else begin
      state_q      <= state_d;
      clr_colour_q <= clr_colour_d;
      clr_addr_q   <= clr_addr_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      dropped_q    <= dropped_d;
    end
  end

endmodule

// File: tb/tb_pixel_write_sink.sv
// Bench for pixel_write_sink: directed phases and random pixels checked against
// an ordered queue of expected framebuffer writes.
module tb_pixel_write_sink;

  localparam int W         = 160;
  localparam int H         = 120;
  localparam int Pixels    = W * H;
  localparam int WaitLimit = 25000;

  logic        clock = 1'b0;
  logic        resetn, plot, ready, clear_req, busy, mem_we;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour, clear_colour, mem_data;
  logic [14:0] mem_addr;
  logic [7:0]  dropped_count;

  typedef struct packed {
    int addr;
    int data;
    int cyc;
  } wr_t;

  wr_t  obs_q[$];
  wr_t  exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   drop_model = 0;
  int   busy_fall_cyc = -1;
  logic busy_prev = 1'b0;

  pixel_write_sink u_dut (
    .clock         (clock),
    .resetn        (resetn),
    .plot          (plot),
    .x             (x),
    .y             (y),
    .colour        (colour),
    .ready         (ready),
    .clear_req     (clear_req),
    .clear_colour  (clear_colour),
    .busy          (busy),
    .mem_addr      (mem_addr),
    .mem_data      (mem_data),
    .mem_we        (mem_we),
    .dropped_count (dropped_count)
  );

  always #10 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Capture every framebuffer write and the cycle busy falls, mid-cycle.
  always @(negedge clock) begin
    if (mem_we === 1'b1) obs_q.push_back('{int'(mem_addr), int'(mem_data), cyc});
    if (busy_prev === 1'b1 && busy === 1'b0) busy_fall_cyc <= cyc;
    busy_prev <= busy;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    plot      = 1'b0;
    clear_req = 1'b0;
    resetn    = 1'b0;
    #1;
    check("rst_ready", ready, 0);
    check("rst_busy", busy, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_data", mem_data, 0);
    check("rst_dropped", dropped_count, 0);
    step();
    step();
    resetn = 1'b1;
    step();
    check("rst_ready_after", ready, 1);
    check("rst_busy_after", busy, 0);
    obs_q.delete();
    exp_q.delete();
    drop_model = 0;
  endtask

  // Holds plot until ready, then records the accepted request in the model.
  task automatic send(input int px, input int py, input int pc, input bit with_clear,
                      input int cc);
    int n;
    n            = 0;
    plot         = 1'b1;
    x            = 8'(px);
    y            = 7'(py);
    colour       = 3'(pc);
    clear_req    = with_clear;
    clear_colour = 3'(cc);
    while (ready !== 1'b1 && n < WaitLimit) begin
      step();
      n++;
    end
    if (n >= WaitLimit) begin
      check("send_ready_timeout", ready, 1);
    end else begin
      step();
      if (px < W && py < H) exp_q.push_back('{py * W + px, pc, cyc + 1});
      else if (drop_model < 255) drop_model++;
    end
    plot      = 1'b0;
    clear_req = 1'b0;
  endtask

  task automatic scoreboard(input string tag);
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check({tag, "_addr"}, obs_q[i].addr, exp_q[i].addr);
      check({tag, "_data"}, obs_q[i].data, exp_q[i].data);
      if (exp_q[i].cyc >= 0) check({tag, "_cyc"}, obs_q[i].cyc, exp_q[i].cyc);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int n;
    int gap;
    int last_clr;
    resetn       = 1'b1;
    plot         = 1'b0;
    clear_req    = 1'b0;
    x            = '0;
    y            = '0;
    colour       = '0;
    clear_colour = '0;
    #2;
    apply_reset();

    // Single write and its latency.
    send(20, 60, 4, 1'b0, 0);
    check("single_we_early", mem_we, 0);
    step();
    check("single_we", mem_we, 1);
    check("single_addr", mem_addr, 9620);
    check("single_data", mem_data, 4);
    step();
    check("single_we_after", mem_we, 0);
    scoreboard("single");

    // Back-to-back burst: one pixel per cycle.
    for (int i = 0; i < 8; i++) begin
      check("burst_ready", ready, 1);
      send(10 + i * 15, 5 + i * 14, i, 1'b0, 0);
    end
    repeat (4) step();
    scoreboard("burst");

    // Random traffic with gaps and some out-of-range requests.
    for (int i = 0; i < 60; i++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) step();
      if ($urandom_range(0, 99) < 15) begin
        if ($urandom_range(0, 1) == 1)
          send($urandom_range(160, 255), $urandom_range(0, 127), $urandom_range(0, 7), 1'b0, 0);
        else
          send($urandom_range(0, 255), $urandom_range(120, 127), $urandom_range(0, 7), 1'b0, 0);
      end else begin
        send($urandom_range(0, 159), $urandom_range(0, 119), $urandom_range(0, 7), 1'b0, 0);
      end
    end
    repeat (4) step();
    scoreboard("random");
    check("random_dropped", dropped_count, drop_model);

    // Range boundaries and saturation of the drop counter.
    apply_reset();
    send(160, 0, 5, 1'b0, 0);
    send(0, 120, 6, 1'b0, 0);
    repeat (3) step();
    check("range_dropped", dropped_count, drop_model);
    scoreboard("range");
    for (int i = 0; i < 300; i++)
      send($urandom_range(160, 255), $urandom_range(0, 127), 0, 1'b0, 0);
    step();
    check("range_saturate", dropped_count, drop_model);

    // Clear with pixels queued, then back-pressure while the fill runs.
    send(30, 10, 2, 1'b0, 0);
    send(31, 10, 3, 1'b0, 0);
    send(32, 10, 5, 1'b1, 1);
    for (int a = 0; a < Pixels; a++) exp_q.push_back('{a, 1, -1});
    check("clear_busy", busy, 1);
    check("clear_ready", ready, 0);
    clear_req    = 1'b1;
    clear_colour = 3'b110;
    repeat (3) step();
    clear_req = 1'b0;
    check("clear_busy_held", busy, 1);
    check("clear_ready_held", ready, 0);
    for (int i = 0; i < 12; i++) send(i * 13, 100 - i, 2 + (i % 6), 1'b0, 0);
    repeat (4) step();
    last_clr = -10;
    if (obs_q.size() > 3 + Pixels - 1) last_clr = obs_q[3 + Pixels - 1].cyc;
    check("clear_busy_fall", busy_fall_cyc, last_clr + 1);
    scoreboard("clear");

    // Reset in the middle of a clear.
    clear_req    = 1'b1;
    clear_colour = 3'b010;
    step();
    clear_req = 1'b0;
    n = 0;
    while (!(mem_we === 1'b1 && mem_addr == 15'd5000) && n < WaitLimit) begin
      step();
      n++;
    end
    check("midclear_addr", mem_addr, 5000);
    check("midclear_busy", busy, 1);
    apply_reset();
    repeat (3) step();
    scoreboard("post_reset_idle");
    send(5, 5, 7, 1'b0, 0);
    repeat (3) step();
    scoreboard("post_reset_write");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pixel_write_sink.md
PIXEL_WRITE_SINK -- requirements
Module: pixel_write_sink

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clock and resetn.
REQ-002 Parameter FIFO_DEPTH, default 8: number of pending pixel-write entries (power of two).
REQ-003 Parameter SCREEN_W, default 160: framebuffer width in pixels.
REQ-004 Parameter SCREEN_H, default 120: framebuffer height in pixels.
REQ-005 Ports SHALL be:
- clock  in  1  system clock (50 MHz)
- resetn  in  1  asynchronous active-low reset
- plot  in  1  pixel-write request valid
- x  in  8  pixel column
- y  in  7  pixel row
- colour  in  3  RGB pixel value, 1 bit per channel
- ready  out  1  request accepted this cycle when plot is high
- clear_req  in  1  single-cycle request to fill the screen
- clear_colour  in  3  fill colour, sampled with clear_req
- busy  out  1  clear sequence in progress
- mem_addr  out  15  framebuffer write address
- mem_data  out  3  framebuffer write data
- mem_we  out  1  framebuffer write strobe
- dropped_count  out  8  count of out-of-range requests

Function
REQ-006 A request SHALL be accepted on any rising edge where plot and ready are both 1.
REQ-007 ready SHALL be 1 only in state IDLE with the FIFO not full; it SHALL be combinational from registered state.
REQ-008 Accepted in-range requests SHALL be enqueued in arrival order. In range means x < SCREEN_W and y < SCREEN_H.
REQ-009 Out-of-range requests SHALL complete the handshake and SHALL NOT be enqueued.
- Each one SHALL increment dropped_count.
- dropped_count SHALL saturate at 255.
REQ-010 In IDLE and DRAIN, one FIFO entry SHALL be popped per cycle whenever the FIFO is non-empty.
REQ-011 Each popped entry SHALL produce registered outputs on the next edge:
- mem_we = 1
- mem_addr = y*SCREEN_W + x, computed as (y<<7)+(y<<5)+x for the defaults, 15-bit result, maximum 19199
- mem_data = colour
REQ-012 Latency: a request accepted at edge N with the FIFO empty SHALL appear with mem_we high in the cycle following edge N+1. Sustained throughput SHALL be one pixel per cycle.
REQ-013 Simultaneous push and pop SHALL be legal whenever ready is 1; occupancy stays unchanged.
REQ-014 The state machine SHALL have three states: IDLE, DRAIN and CLEAR.
- IDLE -> DRAIN on clear_req; clear_colour is latched at this edge.
- DRAIN -> CLEAR when the FIFO is empty.
- CLEAR -> IDLE after the write to address SCREEN_W*SCREEN_H-1.
REQ-015 In CLEAR the block SHALL write addresses 0 through 19199 in order, one per cycle, with mem_data = latched clear_colour.
REQ-016 busy SHALL be 1 in DRAIN and CLEAR, and SHALL fall in the cycle after the final clear write.
REQ-017 clear_req SHALL be ignored outside IDLE.
REQ-018 If plot is accepted in the same cycle as clear_req, the pixel SHALL be enqueued and written before the clear begins.
REQ-019 mem_we SHALL be 0 in any cycle with no pop and no clear write.

Reset
REQ-020 Asserting resetn low SHALL immediately force the following, including mid-clear or mid-drain:
- state IDLE
- FIFO empty (pointers 0)
- mem_we, mem_addr, mem_data = 0
- dropped_count = 0
- busy = 0
REQ-021 ready SHALL be 0 while resetn is low, and SHALL go to 1 in the first cycle after release.
REQ-022 Pending FIFO entries SHALL be discarded on reset.

Structure
REQ-023 A shared package SHALL hold:
- SCREEN_W, SCREEN_H
- colour width (3)
- address width (15)
- the state encoding IDLE/DRAIN/CLEAR
REQ-024 The FIFO SHALL be a separate sub-module, pixel_fifo, with push, pop, full, empty and a 18-bit data word {x, y, colour}.

Verification
REQ-025 Single write: plot x=20, y=60, colour=3'b100 into an idle block -> one cycle of mem_we with mem_addr=9620 and mem_data=3'b100, two edges after acceptance.
REQ-026 Back-pressure: hold plot high with 12 distinct pixels while the drain is stalled by a pending CLEAR -> ready low, no acceptance, then all 12 written in order after busy falls.
REQ-027 Full FIFO: 9 back-to-back requests issued during DRAIN -> ready stays 0 and none are accepted; in IDLE, 8 requests fill and drain with mem_addr in order.
REQ-028 Range: x=160, y=0 then x=0, y=120 -> handshake completes, no mem_we, dropped_count=2; 300 bad requests -> dropped_count=255.
REQ-029 Clear: clear_req with clear_colour=3'b001 and 3 pixels queued -> 3 pixel writes, then 19200 writes at addresses 0..19199 with data 001, busy falling one cycle after address 19199.
REQ-030 Reset mid-clear at address 5000 -> mem_we=0 and busy=0 immediately; ready=1 one cycle after resetn rises.
